// File: rtl/alg_ip_wave_window.sv
`timescale 1ns/1ps
// Purpose : frame-counted capture window with optional RUN/PAUSE duty cycling on one selected channel.
// Latency : every output is registered; events take effect on the edge after the triggering input.
// Backpr. : none; frm_done pulses are sampled every cycle and never stalled.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   frm_done             per-channel frame-done pulses
//   cfg_en               window enable; dropping it aborts to IDLE
//   ch_auto/ch_sel       auto channel pick (lowest active) or manual index
//   start_fr/stop_fr     window open/close frame numbers (0 = immediate / never)
//   high_cyc/low_cyc     RUN/PAUSE lengths in DUTY_SCALE cycles (either 0 disables pausing)
//   dump_active/_paused  window state; on/off/pause/unpause_pulse one-cycle strobes
//   frame_count          saturating count of selected frames; sel_ch/sel_valid selection
module alg_ip_wave_window #(
    parameter int NUM_CH     = 4,
    parameter int FRM_W      = 16,
    parameter int DUTY_SCALE = 1000,
    parameter int CYC_W      = 26,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] frm_done,
    input  logic              cfg_en,
    input  logic              ch_auto,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [FRM_W-1:0]  start_fr,
    input  logic [FRM_W-1:0]  stop_fr,
    input  logic [15:0]       high_cyc,
    input  logic [15:0]       low_cyc,
    output logic              dump_active,
    output logic              dump_paused,
    output logic              on_pulse,
    output logic              off_pulse,
    output logic              pause_pulse,
    output logic              unpause_pulse,
    output logic [FRM_W-1:0]  frame_count,
    output logic [CH_W-1:0]   sel_ch,
    output logic              sel_valid
);

    generate
        if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
            $error("alg_ip_wave_window: NUM_CH must be 1..16");
        end
        if ((64'd1 << CYC_W) <= (64'd65535 * 64'(DUTY_SCALE))) begin : g_bad_cyc_w
            $error("alg_ip_wave_window: CYC_W too narrow for 65535*DUTY_SCALE");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

    localparam int EXT_W = 1 << CH_W;

    state_t             state_q, state_d;
    logic [FRM_W-1:0]   frame_q, frame_d;
    logic [CYC_W-1:0]   duty_q, duty_d;
    logic               auto_lock_q, auto_lock_d;
    logic [CH_W-1:0]    auto_ch_q, auto_ch_d;
    logic               active_q, active_d;
    logic               paused_q, paused_d;
    logic               on_q, on_d;
    logic               off_q, off_d;
    logic               pause_q, pause_d;
    logic               unpause_q, unpause_d;
    logic [CH_W-1:0]    sel_ch_q;
    logic               sel_valid_q;

    // Zero-extended so a manual index beyond NUM_CH reads a 0, never out of range.
    logic [EXT_W-1:0]   frm_ext;
    logic [CH_W-1:0]    low_idx;
    logic [CH_W-1:0]    cur_ch;
    logic               cur_valid;
    logic               auto_latch;
    logic               sel_frm;
    logic [FRM_W:0]     fc_p1;
    logic [FRM_W-1:0]   fc_sat;
    logic               start_hit, stop_hit, open_now, duty_en;
    logic [CYC_W-1:0]   high_load, low_load;

    assign frm_ext = EXT_W'(frm_done);

    // Channel selection. The auto-latch cycle already uses the new choice so
    // the very first frame that triggers the latch is counted.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (frm_done[i]) low_idx = CH_W'(i);
        end
        cur_ch     = '0;
        cur_valid  = 1'b0;
        auto_latch = 1'b0;
        if (!ch_auto) begin
            cur_ch    = ch_sel;
            cur_valid = ({1'b0, ch_sel} < (CH_W + 1)'(NUM_CH));
        end else if (cfg_en && auto_lock_q) begin
            cur_ch    = auto_ch_q;
            cur_valid = 1'b1;
        end else if (cfg_en && (|frm_done)) begin
            cur_ch     = low_idx;
            cur_valid  = 1'b1;
            auto_latch = 1'b1;
        end
    end

    always_comb begin
        auto_lock_d = auto_lock_q;
        auto_ch_d   = auto_ch_q;
        if (!cfg_en || !ch_auto) begin
            auto_lock_d = 1'b0;
            auto_ch_d   = '0;
        end else if (auto_latch) begin
            auto_lock_d = 1'b1;
            auto_ch_d   = low_idx;
        end
    end

    assign sel_frm = cfg_en && cur_valid && frm_ext[cur_ch];

    // One extra bit so frame_count+1 never wraps into a false match.
    assign fc_p1     = {1'b0, frame_q} + (FRM_W + 1)'(1);
    assign fc_sat    = fc_p1[FRM_W] ? frame_q : fc_p1[FRM_W-1:0];
    assign start_hit = sel_frm && (fc_p1 == {1'b0, start_fr});
    assign stop_hit  = sel_frm && (fc_p1 == {1'b0, stop_fr}) && (stop_fr > start_fr);
    assign open_now  = (start_fr == '0) || start_hit;
    assign duty_en   = (high_cyc != '0) && (low_cyc != '0);
    assign high_load = CYC_W'(high_cyc) * CYC_W'(DUTY_SCALE) - CYC_W'(1);
    assign low_load  = CYC_W'(low_cyc) * CYC_W'(DUTY_SCALE) - CYC_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a stop trigger takes priority over a duty expiry.
    always_comb begin
        state_d = state_q;
        if (!cfg_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (open_now) state_d = ST_RUN;
                ST_RUN: begin
                    if (stop_hit)                          state_d = ST_DONE;
                    else if (duty_en && duty_q == '0)      state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (stop_hit)                          state_d = ST_DONE;
                    else if (!duty_en || duty_q == '0)     state_d = ST_RUN;
                end
                default:  state_d = ST_DONE;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        frame_d   = frame_q;
        duty_d    = duty_q;
        on_d      = 1'b0;
        off_d     = 1'b0;
        pause_d   = 1'b0;
        unpause_d = 1'b0;
        if (!cfg_en) begin
            frame_d = '0;
            duty_d  = '0;
            off_d   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
        end else begin
            if (sel_frm) frame_d = fc_sat;
            case (state_q)
                ST_IDLE: begin
                    duty_d = '0;
                    if (open_now) begin
                        on_d   = 1'b1;
                        duty_d = duty_en ? high_load : '0;
                    end
                end
                ST_RUN: begin
                    if (stop_hit) begin
                        off_d  = 1'b1;
                        duty_d = '0;
                    end else if (!duty_en) begin
                        duty_d = '0;
                    end else if (duty_q == '0) begin
                        pause_d = 1'b1;
                        duty_d  = low_load;
                    end else begin
                        duty_d = duty_q - CYC_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (stop_hit) begin
                        off_d  = 1'b1;
                        duty_d = '0;
                    end else if (!duty_en) begin
                        // Pausing switched off mid-pause: resume and park the counter.
                        unpause_d = 1'b1;
                        duty_d    = '0;
                    end else if (duty_q == '0) begin
                        unpause_d = 1'b1;
                        duty_d    = high_load;
                    end else begin
                        duty_d = duty_q - CYC_W'(1);
                    end
                end
                default: duty_d = '0;
            endcase
        end
        active_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
        paused_d = (state_d == ST_PAUSE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_q     <= '0;
            duty_q      <= '0;
            auto_lock_q <= 1'b0;
            auto_ch_q   <= '0;
            active_q    <= 1'b0;
            paused_q    <= 1'b0;
            on_q        <= 1'b0;
            off_q       <= 1'b0;
            pause_q     <= 1'b0;
            unpause_q   <= 1'b0;
            sel_ch_q    <= '0;
            sel_valid_q <= 1'b0;
        end else begin
            frame_q     <= frame_d;
            duty_q      <= duty_d;
            auto_lock_q <= auto_lock_d;
            auto_ch_q   <= auto_ch_d;
            active_q    <= active_d;
            paused_q    <= paused_d;
            on_q        <= on_d;
            off_q       <= off_d;
            pause_q     <= pause_d;
            unpause_q   <= unpause_d;
            sel_ch_q    <= cur_ch;
            sel_valid_q <= cur_valid;
        end
    end

    assign dump_active   = active_q;
    assign dump_paused   = paused_q;
    assign on_pulse      = on_q;
    assign off_pulse     = off_q;
    assign pause_pulse   = pause_q;
    assign unpause_pulse = unpause_q;
    assign frame_count   = frame_q;
    assign sel_ch        = sel_ch_q;
    assign sel_valid     = sel_valid_q;

endmodule

// File: tb/tb_alg_ip_wave_window.sv
`timescale 1ns/1ps
// Purpose : directed, table-driven check of alg_ip_wave_window (NUM_CH=4, FRM_W=4, DUTY_SCALE=1).
// Latency : outputs are sampled 1ns after each rising edge.
// Backpr. : not applicable.
module tb_alg_ip_wave_window;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  frm_done;
    logic        cfg_en;
    logic        ch_auto;
    logic [1:0]  ch_sel;
    logic [3:0]  start_fr;
    logic [3:0]  stop_fr;
    logic [15:0] high_cyc;
    logic [15:0] low_cyc;
    logic        dump_active, dump_paused, on_pulse, off_pulse, pause_pulse, unpause_pulse;
    logic [3:0]  frame_count;
    logic [1:0]  sel_ch;
    logic        sel_valid;

    int checks   = 0;
    int failures = 0;

    alg_ip_wave_window #(
        .NUM_CH(4), .FRM_W(4), .DUTY_SCALE(1), .CYC_W(17)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frm_done(frm_done), .cfg_en(cfg_en),
        .ch_auto(ch_auto), .ch_sel(ch_sel), .start_fr(start_fr), .stop_fr(stop_fr),
        .high_cyc(high_cyc), .low_cyc(low_cyc),
        .dump_active(dump_active), .dump_paused(dump_paused),
        .on_pulse(on_pulse), .off_pulse(off_pulse),
        .pause_pulse(pause_pulse), .unpause_pulse(unpause_pulse),
        .frame_count(frame_count), .sel_ch(sel_ch), .sel_valid(sel_valid)
    );

    always #5 clk = ~clk;

    // Expected output word: {active,paused,on,off,pause,unpause, frame_count, sel_ch, sel_valid}
    typedef struct {
        logic        r;
        logic        c;
        logic        a;
        logic [1:0]  cs;
        logic [3:0]  f;
        logic [3:0]  st;
        logic [3:0]  sp;
        logic [12:0] e;
    } vec_t;

    vec_t tv [19];

    function automatic logic [12:0] ex(input logic [5:0] flg, input logic [3:0] fc,
                                       input logic [1:0] sc, input logic sv);
        return {flg, fc, sc, sv};
    endfunction

    function automatic vec_t mk(input logic r, input logic c, input logic a,
                                input logic [1:0] cs, input logic [3:0] f,
                                input logic [3:0] st, input logic [3:0] sp,
                                input logic [12:0] e);
        vec_t v;
        v.r = r; v.c = c; v.a = a; v.cs = cs; v.f = f; v.st = st; v.sp = sp; v.e = e;
        return v;
    endfunction

    function automatic logic [12:0] obs();
        return {dump_active, dump_paused, on_pulse, off_pulse, pause_pulse, unpause_pulse,
                frame_count, sel_ch, sel_valid};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; frm_done = '0; cfg_en = 1'b0; ch_auto = 1'b0; ch_sel = 2'd2;
        start_fr = 4'd3; stop_fr = 4'd5; high_cyc = '0; low_cyc = '0;

        // Reset, basic window on manual channel 2, then auto selection.
        tv[0]  = mk(1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 4'd3, 4'd5, ex(6'b000000, 4'd0, 2'd0, 1'b0));
        tv[1]  = mk(1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'd3, 4'd5, ex(6'b000000, 4'd0, 2'd2, 1'b1));
        tv[2]  = mk(1'b1, 1'b1, 1'b0, 2'd2, 4'b0000, 4'd3, 4'd5, ex(6'b000000, 4'd0, 2'd2, 1'b1));
        tv[3]  = mk(1'b1, 1'b1, 1'b0, 2'd2, 4'b0100, 4'd3, 4'd5, ex(6'b000000, 4'd1, 2'd2, 1'b1));
        tv[4]  = mk(1'b1, 1'b1, 1'b0, 2'd2, 4'b0000, 4'd3, 4'd5, ex(6'b000000, 4'd1, 2'd2, 1'b1));
        tv[5]  = mk(1'b1, 1'b1, 1'b0, 2'd2, 4'b0100, 4'd3, 4'd5, ex(6'b000000, 4'd2, 2'd2, 1'b1));
        tv[6]  = mk(1'b1, 1'b1, 1'b0, 2'd2, 4'b1011, 4'd3, 4'd5, ex(6'b000000, 4'd2, 2'd2, 1'b1));
        tv[7]  = mk(1'b1, 1'b1, 1'b0, 2'd2, 4'b0100, 4'd3, 4'd5, ex(6'b101000, 4'd3, 2'd2, 1'b1));
        tv[8]  = mk(1'b1, 1'b1, 1'b0, 2'd2, 4'b0000, 4'd3, 4'd5, ex(6'b100000, 4'd3, 2'd2, 1'b1));
        tv[9]  = mk(1'b1, 1'b1, 1'b0, 2'd2, 4'b0100, 4'd3, 4'd5, ex(6'b100000, 4'd4, 2'd2, 1'b1));
        tv[10] = mk(1'b1, 1'b1, 1'b0, 2'd2, 4'b0100, 4'd3, 4'd5, ex(6'b000100, 4'd5, 2'd2, 1'b1));
        tv[11] = mk(1'b1, 1'b1, 1'b0, 2'd2, 4'b0000, 4'd3, 4'd5, ex(6'b000000, 4'd5, 2'd2, 1'b1));
        tv[12] = mk(1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 4'd3, 4'd5, ex(6'b000000, 4'd0, 2'd2, 1'b1));
        tv[13] = mk(1'b1, 1'b1, 1'b1, 2'd2, 4'b0000, 4'd3, 4'd5, ex(6'b000000, 4'd0, 2'd0, 1'b0));
        tv[14] = mk(1'b1, 1'b1, 1'b1, 2'd2, 4'b1010, 4'd3, 4'd5, ex(6'b000000, 4'd1, 2'd1, 1'b1));
        tv[15] = mk(1'b1, 1'b1, 1'b1, 2'd2, 4'b1000, 4'd3, 4'd5, ex(6'b000000, 4'd1, 2'd1, 1'b1));
        tv[16] = mk(1'b1, 1'b1, 1'b1, 2'd2, 4'b0010, 4'd3, 4'd5, ex(6'b000000, 4'd2, 2'd1, 1'b1));
        tv[17] = mk(1'b1, 1'b1, 1'b1, 2'd2, 4'b0001, 4'd3, 4'd5, ex(6'b000000, 4'd2, 2'd1, 1'b1));
        tv[18] = mk(1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 4'd3, 4'd5, ex(6'b000000, 4'd0, 2'd0, 1'b0));

        #2;
        for (int i = 0; i < 19; i++) begin
            rst_n = tv[i].r; cfg_en = tv[i].c; ch_auto = tv[i].a; ch_sel = tv[i].cs;
            frm_done = tv[i].f; start_fr = tv[i].st; stop_fr = tv[i].sp;
            high_cyc = '0; low_cyc = '0;
            tick();
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(tv[i].e));
        end

        // Duty cycling: RUN 3 / PAUSE 2, one frame on ch0 mid-run, then abort in PAUSE.
        rst_n = 1'b0; cfg_en = 1'b0; ch_auto = 1'b0; ch_sel = 2'd0; frm_done = '0;
        tick();
        rst_n = 1'b1;
        tick();
        start_fr = 4'd0; stop_fr = 4'd0; high_cyc = 16'd3; low_cyc = 16'd2; cfg_en = 1'b1;
        for (int k = 0; k < 14; k++) begin
            logic [5:0] want;
            int ph;
            frm_done = (k == 2) ? 4'b0001 : 4'b0000;
            tick();
            ph = k % 5;
            want = {1'b1, (ph >= 3), (k == 0), 1'b0, (ph == 3), (ph == 0 && k > 0)};
            chk($sformatf("duty_k%0d", k), 32'(obs() >> 7), 32'(want));
        end
        chk("duty_frames", 32'(frame_count), 32'd1);
        frm_done = '0; cfg_en = 1'b0;
        tick();
        chk("abort_pause", 32'(obs()), 32'(ex(6'b000100, 4'd0, 2'd0, 1'b1)));
        tick();
        chk("abort_idle", 32'(obs()), 32'(ex(6'b000000, 4'd0, 2'd0, 1'b1)));

        // Stop trigger coincides with duty expiry: only off_pulse.
        start_fr = 4'd1; stop_fr = 4'd3; high_cyc = 16'd3; low_cyc = 16'd2; cfg_en = 1'b1;
        tick();
        chk("svp_idle", 32'(obs()), 32'(ex(6'b000000, 4'd0, 2'd0, 1'b1)));
        frm_done = 4'b0001; tick();
        chk("svp_on", 32'(obs()), 32'(ex(6'b101000, 4'd1, 2'd0, 1'b1)));
        frm_done = 4'b0001; tick();
        chk("svp_run1", 32'(obs()), 32'(ex(6'b100000, 4'd2, 2'd0, 1'b1)));
        frm_done = 4'b0000; tick();
        chk("svp_run2", 32'(obs()), 32'(ex(6'b100000, 4'd2, 2'd0, 1'b1)));
        frm_done = 4'b0001; tick();
        chk("svp_stop", 32'(obs()), 32'(ex(6'b000100, 4'd3, 2'd0, 1'b1)));
        frm_done = 4'b0000; tick();
        chk("svp_done", 32'(obs()), 32'(ex(6'b000000, 4'd3, 2'd0, 1'b1)));

        // Reset during RUN, restart, pausing disabled.
        cfg_en = 1'b0; tick();
        start_fr = 4'd0; stop_fr = 4'd0; high_cyc = 16'd0; low_cyc = 16'd2; cfg_en = 1'b1;
        frm_done = 4'b0001; tick();
        chk("rst_on", 32'(obs()), 32'(ex(6'b101000, 4'd1, 2'd0, 1'b1)));
        tick();
        chk("rst_run", 32'(obs()), 32'(ex(6'b100000, 4'd2, 2'd0, 1'b1)));
        rst_n = 1'b0; tick();
        chk("rst_hold", 32'(obs()), 32'(ex(6'b000000, 4'd0, 2'd0, 1'b0)));
        rst_n = 1'b1; tick();
        chk("rst_restart", 32'(obs()), 32'(ex(6'b101000, 4'd1, 2'd0, 1'b1)));
        frm_done = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("nopause_k%0d", k), 32'(obs()), 32'(ex(6'b100000, 4'd1, 2'd0, 1'b1)));
        end

        // Saturation: 20 frames total on a 4-bit counter.
        for (int n = 2; n <= 20; n++) begin
            frm_done = 4'b0001;
            tick();
            if (n == 14) chk("sat_14", 32'(frame_count), 32'd14);
            if (n == 20) chk("sat_20", 32'(frame_count), 32'd15);
        end
        frm_done = 4'b0000; tick();
        chk("sat_hold", 32'(obs()), 32'(ex(6'b100000, 4'd15, 2'd0, 1'b1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
